// File: rtl/gb_int_ctrl_pkg.sv
// Shared types and constants for the Game Boy interrupt controller.
// No logic; imported by the controller and its priority encoder.
package gb_intc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ACK  = 2'd2,
      ST_DONE = 2'd3
   } intc_state_e;

   localparam logic [2:0] SRC_VBLANK = 3'd0;
   localparam logic [2:0] SRC_STAT   = 3'd1;
   localparam logic [2:0] SRC_TIMER  = 3'd2;
   localparam logic [2:0] SRC_SERIAL = 3'd3;
   localparam logic [2:0] SRC_JOYPAD = 3'd4;

   localparam logic [7:0] VEC_BASE = 8'h40;
   localparam logic [7:0] VEC_STEP = 8'd8;

   function automatic logic [7:0] vec_of(input logic [2:0] idx);
      logic [7:0] off;
      off = VEC_STEP * {5'd0, idx};
      return VEC_BASE + off;
   endfunction

endpackage

// File: rtl/gb_int_ctrl_prio_enc.sv
// Fixed-priority encoder over the pending set; the lowest set bit wins.
// Purely combinational, zero latency, no flow control.
module intc_prio_enc
   import gb_intc_pkg::*;
(
   input  logic [4:0] pend_i,
   output logic       vld_o,
   output logic [2:0] idx_o
);

   always_comb begin
      vld_o = |pend_i;
      idx_o = SRC_VBLANK;
      // Descending scan so the lowest set bit is the last one written.
      for (int i = 4; i >= 0; i--) begin
         if (pend_i[i]) idx_o = 3'(i);
      end
   end

endmodule

// File: rtl/gb_int_ctrl.sv
// Game Boy IF/IE interrupt controller with a Z80-style vectored acknowledge; int_n low 2 edges after a request.
// The CPU holds the ack cycle via IORQ; optional halt-wake pulse under INTC_HALT_WAKE_EN.
module gb_int_ctrl
   import gb_intc_pkg::*;
(
   input  logic       clk,
   input  logic       Reset,
   input  logic [4:0] irq_req,
   input  logic       cpu_m1_n,
   input  logic       cpu_iorq_n,
   input  logic       wr_if,
   input  logic       wr_ie,
   input  logic [7:0] wdata,
   output logic [7:0] IF,
   output logic [7:0] IE,
   output logic       int_n,
   output logic [7:0] vector,
   output logic       vector_oe,
   output logic       wake
);

   logic [4:0]  if_q, if_d;
   logic [7:0]  ie_q, ie_d;
   intc_state_e state_q;
   logic [2:0]  idx_q;
   logic        int_n_q;
   logic [7:0]  vec_q;
   logic        vec_oe_q;

   logic [4:0]  pend;
   logic        pend_vld;
   logic [2:0]  pend_idx;
   logic        unused_wdata;

   assign pend         = if_q & ie_q[4:0];
   assign unused_wdata = ^wdata[7:5];

   intc_prio_enc u_prio (
      .pend_i (pend),
      .vld_o  (pend_vld),
      .idx_o  (pend_idx)
   );

   always_comb begin
      if_d = if_q;
      if (state_q == ST_DONE) if_d = if_d & ~(5'b00001 << idx_q);
      if (wr_if) if_d = wdata[4:0];
      // Requests are ORed last so a same-edge set beats both write and clear.
      if_d = if_d | irq_req;
      ie_d = wr_ie ? wdata : ie_q;
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         if_q <= 5'd0;
         ie_q <= 8'd0;
      end else begin
         if_q <= if_d;
         ie_q <= ie_d;
      end
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= ST_IDLE;
         idx_q    <= SRC_VBLANK;
         int_n_q  <= 1'b1;
         vec_q    <= 8'h00;
         vec_oe_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pend_vld) begin
                  state_q <= ST_REQ;
                  int_n_q <= 1'b0;
               end
            end
            ST_REQ: begin
               // Withdrawal takes precedence over an acknowledge on the same edge.
               if (!pend_vld) begin
                  state_q <= ST_IDLE;
                  int_n_q <= 1'b1;
               end else if (!cpu_m1_n && !cpu_iorq_n) begin
                  state_q  <= ST_ACK;
                  idx_q    <= pend_idx;
                  vec_q    <= vec_of(pend_idx);
                  vec_oe_q <= 1'b1;
               end
            end
            ST_ACK: begin
               if (cpu_iorq_n) begin
                  state_q  <= ST_DONE;
                  int_n_q  <= 1'b1;
                  vec_q    <= 8'h00;
                  vec_oe_q <= 1'b0;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: begin
               state_q  <= ST_IDLE;
               int_n_q  <= 1'b1;
               vec_q    <= 8'h00;
               vec_oe_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef INTC_HALT_WAKE_EN
   logic pend_any_q;

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) pend_any_q <= 1'b0;
      else       pend_any_q <= pend_vld;
   end

   assign wake = pend_vld & ~pend_any_q;
`else
   assign wake = 1'b0;
`endif

   assign IF        = {3'b111, if_q};
   assign IE        = ie_q;
   assign int_n     = int_n_q;
   assign vector    = vec_q;
   assign vector_oe = vec_oe_q;

endmodule

// File: tb/tb_gb_int_ctrl.sv
// Directed self-checking bench for gb_int_ctrl.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_gb_int_ctrl;

   logic       clk;
   logic       Reset;
   logic [4:0] irq_req;
   logic       cpu_m1_n;
   logic       cpu_iorq_n;
   logic       wr_if;
   logic       wr_ie;
   logic [7:0] wdata;
   logic [7:0] if_rd;
   logic [7:0] ie_rd;
   logic       int_n;
   logic [7:0] vector;
   logic       vector_oe;
   logic       wake;

   int checks;
   int fails;

   gb_int_ctrl dut (
      .clk        (clk),
      .Reset      (Reset),
      .irq_req    (irq_req),
      .cpu_m1_n   (cpu_m1_n),
      .cpu_iorq_n (cpu_iorq_n),
      .wr_if      (wr_if),
      .wr_ie      (wr_ie),
      .wdata      (wdata),
      .IF         (if_rd),
      .IE         (ie_rd),
      .int_n      (int_n),
      .vector     (vector),
      .vector_oe  (vector_oe),
      .wake       (wake)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic write_ie(input logic [7:0] v);
      wr_ie = 1'b1; wdata = v;
      step(1);
      wr_ie = 1'b0; wdata = 8'h00;
   endtask

   task automatic write_if(input logic [7:0] v);
      wr_if = 1'b1; wdata = v;
      step(1);
      wr_if = 1'b0; wdata = 8'h00;
   endtask

   task automatic pulse(input logic [4:0] v);
      irq_req = v;
      step(1);
      irq_req = 5'd0;
   endtask

   task automatic test_reset;
      step(2);
      checks++; if (if_rd !== 8'hE0)  begin fails++; $display("FAIL reset_if: got %h want %h", if_rd, 8'hE0); end
      checks++; if (ie_rd !== 8'h00)  begin fails++; $display("FAIL reset_ie: got %h want %h", ie_rd, 8'h00); end
      checks++; if (int_n !== 1'b1)   begin fails++; $display("FAIL reset_int_n: got %b want 1", int_n); end
      checks++; if (vector_oe !== 1'b0) begin fails++; $display("FAIL reset_oe: got %b want 0", vector_oe); end
      checks++; if (vector !== 8'h00) begin fails++; $display("FAIL reset_vector: got %h want 00", vector); end
      checks++; if (wake !== 1'b0)    begin fails++; $display("FAIL reset_wake: got %b want 0", wake); end
      Reset = 1'b0;
      step(1);
   endtask

   task automatic test_single;
      write_ie(8'h04);
      checks++; if (ie_rd !== 8'h04) begin fails++; $display("FAIL single_ie: got %h want 04", ie_rd); end
      pulse(5'b00100);
      checks++; if (if_rd !== 8'hE4) begin fails++; $display("FAIL single_if_set: got %h want E4", if_rd); end
      checks++; if (int_n !== 1'b1)  begin fails++; $display("FAIL single_int_n_n1: got %b want 1", int_n); end
      step(1);
      checks++; if (int_n !== 1'b0)  begin fails++; $display("FAIL single_int_n_n2: got %b want 0", int_n); end
      cpu_m1_n = 1'b0; cpu_iorq_n = 1'b0;
      step(1);
      checks++; if (vector !== 8'h50)  begin fails++; $display("FAIL single_vector: got %h want 50", vector); end
      checks++; if (vector_oe !== 1'b1) begin fails++; $display("FAIL single_oe: got %b want 1", vector_oe); end
      cpu_m1_n = 1'b1; cpu_iorq_n = 1'b1;
      step(1);
      checks++; if (vector_oe !== 1'b0) begin fails++; $display("FAIL single_oe_done: got %b want 0", vector_oe); end
      step(1);
      checks++; if (if_rd !== 8'hE0) begin fails++; $display("FAIL single_if_clr: got %h want E0", if_rd); end
      checks++; if (int_n !== 1'b1)  begin fails++; $display("FAIL single_int_n_end: got %b want 1", int_n); end
   endtask

   task automatic test_priority;
      write_ie(8'h1F);
      pulse(5'b10001);
      checks++; if (if_rd !== 8'hF1) begin fails++; $display("FAIL prio_if: got %h want F1", if_rd); end
      step(1);
      cpu_m1_n = 1'b0; cpu_iorq_n = 1'b0;
      step(1);
      checks++; if (vector !== 8'h40) begin fails++; $display("FAIL prio_vec1: got %h want 40", vector); end
      cpu_m1_n = 1'b1; cpu_iorq_n = 1'b1;
      step(2);
      checks++; if (if_rd !== 8'hF0) begin fails++; $display("FAIL prio_if_mid: got %h want F0", if_rd); end
      step(1);
      checks++; if (int_n !== 1'b0)  begin fails++; $display("FAIL prio_int_n2: got %b want 0", int_n); end
      cpu_m1_n = 1'b0; cpu_iorq_n = 1'b0;
      step(1);
      checks++; if (vector !== 8'h60) begin fails++; $display("FAIL prio_vec2: got %h want 60", vector); end
      cpu_m1_n = 1'b1; cpu_iorq_n = 1'b1;
      step(2);
      checks++; if (if_rd !== 8'hE0) begin fails++; $display("FAIL prio_if_end: got %h want E0", if_rd); end
   endtask

   task automatic test_withdrawal;
      write_ie(8'h08);
      pulse(5'b01000);
      step(1);
      checks++; if (int_n !== 1'b0) begin fails++; $display("FAIL wd_int_n_req: got %b want 0", int_n); end
      write_ie(8'h00);
      step(1);
      checks++; if (int_n !== 1'b1) begin fails++; $display("FAIL wd_int_n: got %b want 1", int_n); end
      cpu_m1_n = 1'b0; cpu_iorq_n = 1'b0;
      step(1);
      checks++; if (vector_oe !== 1'b0) begin fails++; $display("FAIL wd_oe: got %b want 0", vector_oe); end
      cpu_m1_n = 1'b1; cpu_iorq_n = 1'b1;
      checks++; if (if_rd !== 8'hE8) begin fails++; $display("FAIL wd_if: got %h want E8", if_rd); end
      write_if(8'h00);
   endtask

   task automatic test_collision;
      wr_if = 1'b1; wdata = 8'h00; irq_req = 5'b00010;
      step(1);
      wr_if = 1'b0; irq_req = 5'd0;
      checks++; if (if_rd !== 8'hE2) begin fails++; $display("FAIL coll_wr_if: got %h want E2", if_rd); end
      write_if(8'h00);
      write_ie(8'h04);
      pulse(5'b00101);
      step(1);
      cpu_m1_n = 1'b0; cpu_iorq_n = 1'b0;
      step(1);
      checks++; if (vector !== 8'h50) begin fails++; $display("FAIL coll_vec: got %h want 50", vector); end
      cpu_m1_n = 1'b1; cpu_iorq_n = 1'b1;
      step(1);
      pulse(5'b00100);
      checks++; if (if_rd !== 8'hE5) begin fails++; $display("FAIL coll_done_set: got %h want E5", if_rd); end
      step(1);
      checks++; if (int_n !== 1'b0) begin fails++; $display("FAIL coll_rereq: got %b want 0", int_n); end
   endtask

   task automatic test_reset_mid_ack;
      cpu_m1_n = 1'b0; cpu_iorq_n = 1'b0;
      step(1);
      checks++; if (vector_oe !== 1'b1) begin fails++; $display("FAIL rst_pre_oe: got %b want 1", vector_oe); end
      #2 Reset = 1'b1;
      #1;
      checks++; if (int_n !== 1'b1)     begin fails++; $display("FAIL rst_int_n: got %b want 1", int_n); end
      checks++; if (vector_oe !== 1'b0) begin fails++; $display("FAIL rst_oe: got %b want 0", vector_oe); end
      checks++; if (vector !== 8'h00)   begin fails++; $display("FAIL rst_vector: got %h want 00", vector); end
      checks++; if (if_rd !== 8'hE0)    begin fails++; $display("FAIL rst_if: got %h want E0", if_rd); end
      checks++; if (ie_rd !== 8'h00)    begin fails++; $display("FAIL rst_ie: got %h want 00", ie_rd); end
      cpu_m1_n = 1'b1; cpu_iorq_n = 1'b1;
      step(2);
      Reset = 1'b0;
      step(1);
   endtask

   task automatic test_wake;
      int pulses;
      logic exp_first;
      int exp_pulses;
`ifdef INTC_HALT_WAKE_EN
      exp_first  = 1'b1;
      exp_pulses = 1;
`else
      exp_first  = 1'b0;
      exp_pulses = 0;
`endif
      write_ie(8'h01);
      checks++; if (wake !== 1'b0) begin fails++; $display("FAIL wake_idle: got %b want 0", wake); end
      pulses = 0;
      pulse(5'b00001);
      checks++; if (wake !== exp_first) begin fails++; $display("FAIL wake_first: got %b want %b", wake, exp_first); end
      if (wake === 1'b1) pulses++;
      for (int i = 0; i < 5; i++) begin
         step(1);
         if (wake === 1'b1) pulses++;
      end
      checks++; if (pulses != exp_pulses) begin fails++; $display("FAIL wake_count: got %0d want %0d", pulses, exp_pulses); end
   endtask

   initial begin
      checks     = 0;
      fails      = 0;
      Reset      = 1'b1;
      irq_req    = 5'd0;
      cpu_m1_n   = 1'b1;
      cpu_iorq_n = 1'b1;
      wr_if      = 1'b0;
      wr_ie      = 1'b0;
      wdata      = 8'h00;
      test_reset;
      test_single;
      test_priority;
      test_withdrawal;
      test_collision;
      test_reset_mid_ack;
      test_wake;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/gb_int_ctrl.md
GB_INT_CTRL -- requirements
Module: gb_int_ctrl

Interface
REQ-001 SHALL have a single clock and an asynchronous active-high reset, declared first:
- clk  in  1  gameboy clock
- Reset  in  1  asynchronous, active-high
REQ-002 SHALL have the following remaining ports:
- irq_req  in  5  one-cycle request pulses; bit0 VBlank, bit1 STAT, bit2 Timer, bit3 Serial, bit4 Joypad
- cpu_m1_n  in  1  Z80 M1 strobe
- cpu_iorq_n  in  1  Z80 IORQ strobe
- wr_if  in  1  write strobe for IF (FF0F)
- wr_ie  in  1  write strobe for IE (FFFF)
- wdata  in  8  write data
- IF  out  8  IF readback
- IE  out  8  IE readback
- int_n  out  1  active-low interrupt to the CPU
- vector  out  8  acknowledge vector byte
- vector_oe  out  1  vector drives the CPU data input
- wake  out  1  halt-wake pulse (see REQ-019)

Function
REQ-003 IF SHALL read {3'b111, if_q[4:0]}; IE SHALL read all 8 stored bits.
REQ-004 The pending set SHALL be pend = if_q[4:0] & ie_q[4:0].
REQ-005 Priority SHALL be fixed: the lowest set bit of pend wins.
REQ-006 vector SHALL be 8'h40 + 8 * index, giving 40/48/50/58/60.
REQ-007 The FSM SHALL have four states: IDLE, REQ, ACK, DONE.
REQ-008 IDLE -> REQ SHALL occur on the edge after pend != 0; int_n SHALL be registered and low in REQ and ACK only.
REQ-009 REQ -> ACK SHALL occur when cpu_m1_n = 0 and cpu_iorq_n = 0. The winning index SHALL be latched on that edge.
REQ-010 In ACK, vector_oe SHALL be 1 and vector SHALL hold the latched value, ignoring later pend changes.
REQ-011 ACK -> DONE SHALL occur when cpu_iorq_n returns high. In DONE, if_q[latched index] SHALL be cleared, and the next state SHALL be IDLE.
REQ-012 In REQ, if pend falls to 0 (IF or IE rewritten), the FSM SHALL return to IDLE with int_n high on the next edge and no acknowledge.
REQ-013 An irq_req bit SHALL set its if_q bit on the next edge, regardless of IE.
REQ-014 wr_if SHALL load wdata[4:0]; a simultaneous irq_req SHALL be ORed after the write, so set wins.
REQ-015 A DONE clear and a simultaneous irq_req on the same bit SHALL leave the bit set; other bits SHALL be unaffected by the clear.
REQ-016 wr_ie SHALL load all 8 bits on the next edge.
REQ-017 Latency from an irq_req pulse at edge N (bit enabled, IDLE) SHALL be: if_q set at N+1, int_n low at N+2.

Reset
REQ-018 Reset SHALL asynchronously force the following, including mid-ACK:
- if_q = 0, ie_q = 0, FSM = IDLE
- int_n = 1, vector_oe = 0, vector = 8'h00, wake = 0

Configuration
REQ-019 With INTC_HALT_WAKE_EN defined, wake SHALL pulse for one cycle on each 0 -> nonzero transition of pend, independent of FSM state.
REQ-020 Without INTC_HALT_WAKE_EN, wake SHALL be tied 0 and no edge-detect register SHALL exist.

Structure
REQ-021 Package gb_intc_pkg SHALL hold:
- the FSM state enum
- source index constants (VBLANK=0 to JOYPAD=4)
- VEC_BASE = 8'h40 and VEC_STEP = 8
REQ-022 A sub-module intc_prio_enc SHALL map 5-bit pend to {valid, 3-bit index}.
REQ-023 The total RTL SHALL be 120 to 400 lines.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Single source: IE=8'h04, Timer pulse -> int_n low 2 cycles later; on M1+IORQ, vector=8'h50 and vector_oe=1; after IORQ high, IF=8'hE0 and int_n=1.
- Priority: IE=8'h1F, Joypad and VBlank pulses in the same cycle -> first ack vector 8'h40 with IF bit4 still set; second ack vector 8'h60.
- Withdrawal: Serial pending with IE=8'h08, in REQ write IE=8'h00 -> int_n high next cycle, no vector_oe, IF bit3 still set.
- Collisions: wr_if wdata=8'h00 with simultaneous STAT pulse -> IF=8'hE2; Timer pulse in the DONE cycle of a Timer ack -> bit2 stays set.
- Reset mid-ACK: assert Reset while vector_oe=1 -> immediately int_n=1, vector_oe=0, IF=8'hE0, IE=8'h00.
- With INTC_HALT_WAKE_EN: IE=8'h01, VBlank pulse -> a single one-cycle wake pulse; without the macro, wake stays 0.
